// File: rtl/pipe_addsub.sv
// rtl/pipe_addsub.sv - pipelined add/subtract unit, carry rippling one chunk per stage
// Stage k adds chunk k; the final stage also applies overflow detection and saturation.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_value_a,
  input  logic [WIDTH-1:0] i_value_b,
  input  logic             i_sub,
  input  logic [1:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_result,
  output logic             o_carry,
  output logic             o_overflow
);

  localparam int CW = WIDTH / STAGES;
  localparam int L  = STAGES - 1;

  logic [STAGES:0]   en;
  logic [STAGES-1:0] vld, c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [2:0]        ctl_q [STAGES];

  logic [STAGES-1:0] vld_in, c_in;
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [WIDTH-1:0]  s_d  [STAGES];
  logic [2:0]        ctl_in [STAGES];
  logic [CW:0]       csum [STAGES];

  logic [WIDTH-1:0]  raw, sat_val, res_d;
  logic              carry_f, ovf_d, ovf_q;
  logic              a_msb, b_msb, r_msb;

  // Bubble-collapsing advance: a stage moves when empty or when the next one moves.
  always_comb begin
    en[STAGES] = i_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      en[k] = !vld[k] || en[k+1];
    end
  end

  assign o_ready = en[0];

  // Stage inputs: stage 0 takes the port (B inverted for sub), later stages take the previous register.
  always_comb begin
    vld_in[0] = i_valid;
    a_in[0]   = i_value_a;
    b_in[0]   = i_sub ? ~i_value_b : i_value_b;
    c_in[0]   = i_sub;
    s_in[0]   = '0;
    ctl_in[0] = {i_sub, i_mode};
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      c_in[k]   = c_q[k-1];
      s_in[k]   = s_q[k-1];
      ctl_in[k] = ctl_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      csum[k] = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
              + {{CW{1'b0}}, c_in[k]};
      s_d[k]  = s_in[k];
      s_d[k][k*CW +: CW] = csum[k][CW-1:0];
    end
  end

  // Final-stage mode handling; ctl is {sub, signed, saturate}.
  always_comb begin
    raw     = s_d[L];
    carry_f = csum[L][CW];
    a_msb   = a_in[L][WIDTH-1];
    b_msb   = b_in[L][WIDTH-1];
    r_msb   = raw[WIDTH-1];
    if (ctl_in[L][1]) begin
      ovf_d   = (a_msb == b_msb) && (r_msb != a_msb);
      sat_val = a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end else begin
      ovf_d   = ctl_in[L][2] ? !carry_f : carry_f;
      sat_val = ctl_in[L][2] ? '0 : '1;
    end
    res_d = (ctl_in[L][0] && ovf_d) ? sat_val : raw;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        s_q[k]   <= '0;
        ctl_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) begin
          vld[k] <= vld_in[k];
          if (vld_in[k]) begin
            a_q[k]   <= a_in[k];
            b_q[k]   <= b_in[k];
            s_q[k]   <= (k == L) ? res_d : s_d[k];
            c_q[k]   <= csum[k][CW];
            ctl_q[k] <= ctl_in[k];
          end
        end
      end
      if (en[L] && vld_in[L]) begin
        ovf_q <= ovf_d;
      end
    end
  end

  assign o_valid    = vld[L];
  assign o_result   = s_q[L];
  assign o_carry    = c_q[L];
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// tb/tb_pipe_addsub.sv - self-checking bench for pipe_addsub (8-bit/2-stage and 32-bit/4-stage)
// Expected results come from integer arithmetic on the operands, pinned by a literal vector table.
module tb_pipe_addsub;

  localparam int S8  = 2;
  localparam int S32 = 4;

  typedef struct {
    logic [33:0] exp;
    int          acc;
    int          st;
    bit          lit;
    logic [9:0]  litv;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_ready, sub;
  logic [1:0]  mode;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        o_ready8, o_valid8, carry8, ovf8;
  logic [7:0]  res8;
  logic        o_ready32, o_valid32, carry32, ovf32;
  logic [31:0] res32;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(8), .STAGES(S8)) u8 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready8),
    .i_value_a(a8), .i_value_b(b8), .i_sub(sub), .i_mode(mode),
    .o_valid(o_valid8), .i_ready(i_ready), .o_result(res8),
    .o_carry(carry8), .o_overflow(ovf8)
  );

  pipe_addsub #(.WIDTH(32), .STAGES(S32)) u32 (
    .i_clk(clk), .i_rst(rst), .i_valid(i_valid), .o_ready(o_ready32),
    .i_value_a(a32), .i_value_b(b32), .i_sub(sub), .i_mode(mode),
    .o_valid(o_valid32), .i_ready(i_ready), .o_result(res32),
    .o_carry(carry32), .o_overflow(ovf32)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         stalls = 0;
  int         acc8 = 0;
  bit         prev8 = 0, prev32 = 0;
  logic       lit_on = 1'b0;
  logic [9:0] lit_val = '0;
  beat_t      q8[$];
  beat_t      q32[$];
  beat_t      e8, e32;
  logic [28:0] vec [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns {overflow, carry, result}; result zero-extended to 32 bits.
  function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                        input logic s, input logic [1:0] m);
    longint ua, ub, mask, sa, sb, sr, mx, mn, r;
    logic c, ov;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    if (s) begin
      r = (ua - ub) & mask;
      c = (ua >= ub);
    end else begin
      r = (ua + ub) & mask;
      c = ((ua + ub) >> w) != 0;
    end
    sa = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
    sb = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
    sr = s ? sa - sb : sa + sb;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -(longint'(1) << (w - 1));
    if (m[1]) begin
      ov = (sr > mx) || (sr < mn);
      if (m[0] && ov) r = (sr > mx) ? mx : (mn & mask);
    end else begin
      ov = s ? !c : c;
      if (m[0] && ov) r = s ? 0 : mask;
    end
    return {ov, c, 32'(r)};
  endfunction

  function automatic logic [31:0] pick32();
    logic [31:0] corner [4];
    corner[0] = 32'h0000_0000;
    corner[1] = 32'hFFFF_FFFF;
    corner[2] = 32'h8000_0000;
    corner[3] = 32'h7FFF_FFFF;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      q8.delete();
      q32.delete();
      prev8  = 0;
      prev32 = 0;
      check("rst_valid8", {63'b0, o_valid8}, 64'd0);
      check("rst_ready8", {63'b0, o_ready8}, 64'd1);
      check("rst_out8", {54'b0, ovf8, carry8, res8}, 64'd0);
      check("rst_valid32", {63'b0, o_valid32}, 64'd0);
      check("rst_ready32", {63'b0, o_ready32}, 64'd1);
    end else begin
      if (prev8) check("stall_hold8", {63'b0, o_valid8}, 64'd1);
      if (o_valid8) begin
        if (q8.size() == 0) check("spurious8", {63'b0, o_valid8}, 64'd0);
        else begin
          check("data8", {30'b0, ovf8, carry8, 24'b0, res8}, {30'b0, q8[0].exp});
          if (q8[0].lit) check("literal8", {54'b0, ovf8, carry8, res8}, {54'b0, q8[0].litv});
          if (stalls == q8[0].st) check("latency8", 64'(cyc), 64'(q8[0].acc + S8 - 1));
          if (i_ready) void'(q8.pop_front());
        end
      end
      prev8 = o_valid8 && !i_ready;

      if (prev32) check("stall_hold32", {63'b0, o_valid32}, 64'd1);
      if (o_valid32) begin
        if (q32.size() == 0) check("spurious32", {63'b0, o_valid32}, 64'd0);
        else begin
          check("data32", {30'b0, ovf32, carry32, res32}, {30'b0, q32[0].exp});
          if (stalls == q32[0].st) check("latency32", 64'(cyc), 64'(q32[0].acc + S32 - 1));
          if (i_ready) void'(q32.pop_front());
        end
      end
      prev32 = o_valid32 && !i_ready;

      if (!i_ready) stalls++;
      if (i_ready) begin
        check("rate8", {63'b0, o_ready8}, 64'd1);
        check("rate32", {63'b0, o_ready32}, 64'd1);
      end

      if (i_valid && o_ready8) begin
        e8.exp  = model(8, {24'b0, a8}, {24'b0, b8}, sub, mode);
        e8.acc  = cyc + 1;
        e8.st   = stalls;
        e8.lit  = lit_on;
        e8.litv = lit_val;
        q8.push_back(e8);
        acc8++;
        if (lit_on) check("model_pin", {54'b0, e8.exp[33:32], e8.exp[7:0]}, {54'b0, lit_val});
      end
      if (i_valid && o_ready32) begin
        e32.exp  = model(32, a32, b32, sub, mode);
        e32.acc  = cyc + 1;
        e32.st   = stalls;
        e32.lit  = 1'b0;
        e32.litv = '0;
        q32.push_back(e32);
      end
    end
  end

  task automatic drive_vec(input int idx);
    logic [28:0] v;
    v = vec[idx];
    @(posedge clk); #1;
    i_valid = 1'b1;
    sub     = v[28];
    mode    = v[27:26];
    a8      = v[25:18];
    b8      = v[17:10];
    a32     = pick32();
    b32     = pick32();
    lit_on  = 1'b1;
    lit_val = v[9:0];
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    i_valid = 1'b0;
    lit_on  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // {sub, mode, a, b, ovf, carry, result}
    vec[0]  = {1'b0, 2'b00, 8'hF0, 8'h20, 1'b1, 1'b1, 8'h10};
    vec[1]  = {1'b0, 2'b01, 8'hF0, 8'h20, 1'b1, 1'b1, 8'hFF};
    vec[2]  = {1'b1, 2'b01, 8'h10, 8'h20, 1'b1, 1'b0, 8'h00};
    vec[3]  = {1'b1, 2'b01, 8'h20, 8'h10, 1'b0, 1'b1, 8'h10};
    vec[4]  = {1'b0, 2'b11, 8'h70, 8'h20, 1'b1, 1'b0, 8'h7F};
    vec[5]  = {1'b1, 2'b11, 8'h80, 8'h01, 1'b1, 1'b1, 8'h80};
    vec[6]  = {1'b1, 2'b10, 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F};
    vec[7]  = {1'b1, 2'b00, 8'h05, 8'h07, 1'b1, 1'b0, 8'hFE};
    vec[8]  = {1'b0, 2'b10, 8'h7F, 8'h01, 1'b1, 1'b0, 8'h80};
    vec[9]  = {1'b0, 2'b11, 8'hFF, 8'h01, 1'b0, 1'b1, 8'h00};
    vec[10] = {1'b0, 2'b01, 8'h12, 8'h34, 1'b0, 1'b0, 8'h46};
    vec[11] = {1'b1, 2'b11, 8'h7F, 8'hFF, 1'b1, 1'b0, 8'h7F};

    rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1; sub = 1'b0; mode = 2'b00;
    a8 = '0; b8 = '0; a32 = '0; b32 = '0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      i_valid = $urandom_range(0, 1) == 1;
      a8 = 8'($urandom); b8 = 8'($urandom); a32 = $urandom; b32 = $urandom;
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    rst = 1'b0;

    for (int i = 0; i < 12; i++) drive_vec(i);
    idle(8);

    // Back-pressure: fill both pipes, hold, then release.
    i_ready = 1'b0;
    for (int i = 0; i < 6; i++) drive_vec(i);
    idle(4);
    i_ready = 1'b1;
    idle(8);

    for (int i = 0; i < 8000 && acc8 < 1000; i++) begin
      @(posedge clk); #1;
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 3) != 0;
      sub     = $urandom_range(0, 1) == 1;
      mode    = 2'($urandom_range(0, 3));
      a32     = pick32();
      b32     = pick32();
      a8      = 8'(pick32() >> 24);
      b8      = 8'(pick32() >> 24);
    end
    check("random_count", {63'b0, acc8 >= 1000}, 64'd1);
    i_ready = 1'b1;
    idle(12);
    check("drain8", 64'(q8.size()), 64'd0);
    check("drain32", 64'(q32.size()), 64'd0);

    // Mid-stream reset with the pipes full.
    i_ready = 1'b0;
    for (int i = 6; i < 12; i++) drive_vec(i);
    idle(1);
    check("filled8", {63'b0, o_valid8}, 64'd1);
    check("filled32", {63'b0, o_valid32}, 64'd1);
    rst = 1'b1;
    #1;
    check("rst_drop8", {63'b0, o_valid8}, 64'd0);
    check("rst_drop32", {63'b0, o_valid32}, 64'd0);
    check("rst_ready8", {63'b0, o_ready8}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    i_ready = 1'b1;
    repeat (4) @(posedge clk);
    drive_vec(3);
    idle(8);
    check("post_rst_drain8", 64'(q8.size()), 64'd0);
    check("post_rst_drain32", 64'(q32.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
